// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, issues one imem request at a time and
// drives the IF/ID register, with a one-entry skid for responses that arrive during a stall.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Redirect_i,
  input  logic [31:0] RedirectPC_i,
  output logic        ImemReq_o,
  output logic [31:0] ImemAddr_o,
  input  logic        ImemAck_i,
  input  logic [31:0] ImemRdata_i,
  output logic [31:0] Inst_o,
  output logic [31:0] PC_o,
  output logic        Valid_o
);

  typedef enum logic [1:0] {StIssue, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_q, skid_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        idif_free;

  assign idif_free = !Stall_i || !valid_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    skid_d   = skid_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;

    // IF/ID drains whenever decode accepts; a load below overrides this.
    if (!Stall_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end

    unique case (state_q)
      StIssue: begin
        // req_q is low only in the first cycle after reset, when nothing has gone out yet.
        if (req_q) state_d = StWait;
      end
      StWait: begin
        if (ImemAck_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StIssue;
          end else if (idif_free) begin
            inst_d   = ImemRdata_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_d  = StIssue;
          end else begin
            skid_d  = ImemRdata_i;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // pc_q is frozen in HOLD, so it is the PC of the skid word.
        if (!Stall_i) begin
          inst_d   = skid_q;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase

    if (Redirect_i) begin
      pc_d    = RedirectPC_i & 32'hFFFF_FFFC;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      unique case (state_q)
        StIssue: begin
          if (req_q) begin
            kill_d  = 1'b1;
            state_d = StWait;
          end
        end
        StWait: begin
          if (ImemAck_i) begin
            kill_d  = 1'b0;
            state_d = StIssue;
          end else begin
            kill_d  = 1'b1;
            state_d = StWait;
          end
        end
        default: state_d = StIssue;
      endcase
    end

    req_d  = (state_d == StIssue);
    addr_d = req_d ? pc_d : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIssue;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      skid_q   <= 32'd0;
      req_q    <= 1'b0;
      addr_q   <= 32'd0;
      inst_q   <= NOP_INST;
      pc_out_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      skid_q   <= skid_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign ImemReq_o  = req_q;
  assign ImemAddr_o = addr_q;
  assign Inst_o     = inst_q;
  assign PC_o       = pc_out_q;
  assign Valid_o    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a latency-programmable memory, a transaction-level fetch model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        Stall_i = 1'b0;
  logic        Redirect_i = 1'b0;
  logic [31:0] RedirectPC_i = 32'd0;
  logic        ImemReq_o;
  logic [31:0] ImemAddr_o;
  logic        ImemAck_i = 1'b0;
  logic [31:0] ImemRdata_i = 32'd0;
  logic [31:0] Inst_o;
  logic [31:0] PC_o;
  logic        Valid_o;

  if_stage dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .Stall_i     (Stall_i),
    .Redirect_i  (Redirect_i),
    .RedirectPC_i(RedirectPC_i),
    .ImemReq_o   (ImemReq_o),
    .ImemAddr_o  (ImemAddr_o),
    .ImemAck_i   (ImemAck_i),
    .ImemRdata_i (ImemRdata_i),
    .Inst_o      (Inst_o),
    .PC_o        (PC_o),
    .Valid_o     (Valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected outputs of the current cycle plus fetch bookkeeping.
  bit          m_init = 0;
  bit          m_req, m_valid, m_inflight, m_stale, m_pend;
  logic [31:0] m_addr, m_inst, m_pco, m_pc, m_pend_inst;

  // Memory model.
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 0;
  int          kmin = 1, kmax = 1;
  bit          inject_ack = 0;

  // Outputs sampled in the most recent cycle.
  bit          s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;
  int          since_reset = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_addr = 0; m_valid = 0; m_inst = Nop; m_pco = 0; m_pc = 0;
    m_inflight = 0; m_stale = 0; m_pend = 0; m_pend_inst = 0; m_init = 1;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit ack, input logic [31:0] rdata);
    bit          n_valid, n_inflight, n_stale, n_pend;
    logic [31:0] n_inst, n_pco, n_pc, n_pend_inst;
    n_valid = st ? m_valid : 1'b0;
    n_inst  = st ? m_inst : Nop;
    n_pco = m_pco; n_pc = m_pc;
    n_inflight = m_inflight || m_req;
    n_stale = m_stale; n_pend = m_pend; n_pend_inst = m_pend_inst;
    if (m_inflight && ack) begin
      n_inflight = 0;
      if (m_stale) n_stale = 0;
      else if (!st || !m_valid) begin
        n_valid = 1; n_inst = rdata; n_pco = m_pc; n_pc = m_pc + 32'd4;
      end else begin
        n_pend = 1; n_pend_inst = rdata;
      end
    end else if (m_pend && !st) begin
      n_valid = 1; n_inst = m_pend_inst; n_pco = m_pc; n_pc = m_pc + 32'd4; n_pend = 0;
    end
    if (rd) begin
      n_pc = rpc & 32'hFFFF_FFFC; n_valid = 0; n_inst = Nop; n_pend = 0;
      if (n_inflight) n_stale = 1;
    end
    m_valid = n_valid; m_inst = n_inst; m_pco = n_pco; m_pc = n_pc;
    m_inflight = n_inflight; m_stale = n_stale; m_pend = n_pend; m_pend_inst = n_pend_inst;
    m_req  = !n_inflight && !n_pend;
    m_addr = m_req ? n_pc : 32'd0;
  endtask

  // One clock cycle: compare outputs, run memory, drive inputs, advance the model.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit rs);
    bit          ack;
    logic [31:0] rdata;
    @(negedge clk);
    s_req = ImemReq_o; s_addr = ImemAddr_o; s_valid = Valid_o; s_inst = Inst_o; s_pc = PC_o;
    if (m_init) begin
      check("req", {31'd0, s_req}, {31'd0, m_req});
      if (m_req) check("addr", s_addr, m_addr);
      check("valid", {31'd0, s_valid}, {31'd0, m_valid});
      check("inst", s_inst, m_inst);
      if (m_valid) check("pc", s_pc, m_pco);
    end
    ack = 0; rdata = 32'd0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        ack = 1; rdata = mem_addr ^ 32'hA5A5_0000; mem_busy = 0;
      end
    end
    if (inject_ack) begin
      ack = 1; rdata = 32'hDEAD_BEEF; inject_ack = 0;
    end
    if (s_req && !mem_busy) begin
      mem_busy = 1; mem_cnt = $urandom_range(kmax, kmin); mem_addr = s_addr;
    end
    if (rs) mem_busy = 0;
    rst_i = rs; Stall_i = st; Redirect_i = rd; RedirectPC_i = rpc;
    ImemAck_i = ack; ImemRdata_i = rdata;
    if (rs) model_reset();
    else if (m_init) model_step(st, rd, rpc, ack, rdata);
    since_reset = rs ? 0 : since_reset + 1;
  endtask

  task automatic reset_dut(input string tag);
    cycle(0, 0, 32'd0, 1);
    cycle(0, 0, 32'd0, 1);
    check({tag, "_rst_valid"}, {31'd0, s_valid}, 32'd0);
    check({tag, "_rst_inst"}, s_inst, Nop);
    check({tag, "_rst_req"}, {31'd0, s_req}, 32'd0);
    check({tag, "_rst_pc"}, s_pc, 32'd0);
  endtask

  initial begin
    int          vcyc[$];
    logic [31:0] vinst[$], vpc[$], raddr[$];

    // Back-to-back fetch at k=1.
    reset_dut("s1");
    kmin = 1; kmax = 1;
    for (int i = 0; i < 11; i++) begin
      cycle(0, 0, 32'd0, 0);
      if (s_valid) begin vcyc.push_back(i); vinst.push_back(s_inst); vpc.push_back(s_pc); end
      if (s_req) raddr.push_back(s_addr);
    end
    check("s1_nvalid", vinst.size(), 32'd4);
    check("s1_req0", raddr[0], 32'h0);
    check("s1_req1", raddr[1], 32'h4);
    check("s1_req2", raddr[2], 32'h8);
    check("s1_inst0", vinst[0], 32'hA5A5_0000);
    check("s1_pc0", vpc[0], 32'h0);
    check("s1_inst1", vinst[1], 32'hA5A5_0004);
    check("s1_pc1", vpc[1], 32'h4);
    check("s1_inst2", vinst[2], 32'hA5A5_0008);
    check("s1_pc2", vpc[2], 32'h8);
    check("s1_gap01", vcyc[1] - vcyc[0], 32'd2);
    check("s1_gap12", vcyc[2] - vcyc[1], 32'd2);

    // Stall for 5 cycles while valid, with an ack landing in the skid.
    reset_dut("s2");
    for (int i = 0; i < 11; i++) begin
      cycle((i >= 3 && i <= 7), 0, 32'd0, 0);
      if (i >= 4 && i <= 8) begin
        check("s2_hold_inst", s_inst, 32'hA5A5_0000);
        check("s2_hold_pc", s_pc, 32'h0);
        check("s2_hold_noreq", {31'd0, s_req}, 32'd0);
      end
      if (i == 9) begin
        check("s2_skid_inst", s_inst, 32'hA5A5_0004);
        check("s2_skid_pc", s_pc, 32'h4);
        check("s2_next_addr", s_addr, 32'h8);
      end
    end

    // k=3, redirect one cycle after the request to 0x10.
    reset_dut("s3");
    kmin = 3; kmax = 3;
    for (int i = 0; i < 26; i++) begin
      cycle(0, (i == 18), 32'h0000_0100, 0);
      if (i == 17) check("s3_req10", s_addr, 32'h10);
      if (i >= 18 && i <= 24) check("s3_killed", {31'd0, s_valid}, 32'd0);
      if (i == 21) begin
        check("s3_req100", {31'd0, s_req}, 32'd1);
        check("s3_addr100", s_addr, 32'h100);
      end
      if (i == 25) begin
        check("s3_valid", {31'd0, s_valid}, 32'd1);
        check("s3_pc", s_pc, 32'h100);
        check("s3_inst", s_inst, 32'hA5A5_0100);
      end
    end

    // Redirect coinciding with ack under stall, unaligned target.
    reset_dut("s4");
    kmin = 1; kmax = 1;
    for (int i = 0; i < 6; i++) begin
      cycle((i == 2), (i == 2), 32'h0000_0203, 0);
      if (i == 3) begin
        check("s4_valid", {31'd0, s_valid}, 32'd0);
        check("s4_inst", s_inst, Nop);
        check("s4_req", {31'd0, s_req}, 32'd1);
        check("s4_addr", s_addr, 32'h200);
      end
      if (i == 5) check("s4_pc", s_pc, 32'h200);
    end

    // PC wrap at the top of the address space.
    reset_dut("s5");
    for (int i = 0; i < 8; i++) begin
      cycle(0, (i == 2), 32'hFFFF_FFFC, 0);
      if (i == 3) check("s5_addr_top", s_addr, 32'hFFFF_FFFC);
      if (i == 5) begin
        check("s5_pc_top", s_pc, 32'hFFFF_FFFC);
        check("s5_inst_top", s_inst, 32'h5A5A_FFFC);
        check("s5_wrap_addr", s_addr, 32'h0);
      end
      if (i == 7) check("s5_pc_zero", s_pc, 32'h0);
    end

    // Reset while waiting, followed by a late ack for the old request.
    reset_dut("s6");
    kmin = 3; kmax = 3;
    cycle(0, 0, 32'd0, 0);
    cycle(0, 0, 32'd0, 0);
    reset_dut("s6b");
    kmin = 1; kmax = 1;
    inject_ack = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 32'd0, 0);
      if (i == 1) begin
        check("s6_valid", {31'd0, s_valid}, 32'd0);
        check("s6_inst", s_inst, Nop);
        check("s6_req", {31'd0, s_req}, 32'd1);
        check("s6_addr", s_addr, 32'h0);
      end
      if (i == 3) check("s6_first_inst", s_inst, 32'hA5A5_0000);
    end

    // Random traffic against the model.
    reset_dut("s7");
    kmin = 1; kmax = 4;
    for (int i = 0; i < 4000; i++) begin
      bit          st, rd, rs;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 30);
      rd  = (since_reset >= 2) && ($urandom_range(0, 99) < 4);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rs  = ($urandom_range(0, 499) == 0);
      cycle(st, rd, rpc, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
